// File: rtl/riscv_pkg.sv
// Shared pipeline constants: canonical NOP, forwarding-select encodings and small helpers.
package riscv_pkg;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [1:0]  FWD_REG = 2'b00;
    localparam logic [1:0]  FWD_WB  = 2'b01;
    localparam logic [1:0]  FWD_MEM = 2'b10;

    // Encoding 2'b11 is unused and falls back to the register-file operand.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] wb_val,
                                            input logic [31:0] mem_val);
        logic [31:0] res;
        case (sel)
            FWD_WB:  res = wb_val;
            FWD_MEM: res = mem_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset value, sync clear (wins over enable), load enable.
module pipe_reg
    import riscv_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             ien,
    input  logic             iclr,
    input  logic [WIDTH-1:0] idata,
    output logic [WIDTH-1:0] odata
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (iclr) begin
            data_d = CLR_VAL;
        end else if (ien) begin
            data_d = idata;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign odata = data_q;

endmodule

// File: rtl/pipe_front_regs.sv
// Front-end pipeline state: PC, IF/ID and ID/EX registers, EX operand forwarding and
// stall/flush performance counters.
module pipe_front_regs
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CTRL_W   = 16
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istall_fetch,
    input  logic              istall_decod,
    input  logic              iflush_decod,
    input  logic              iflush_exect,
    input  logic [31:0]       ipc_next_fetch,
    input  logic [31:0]       ipc_fetch_plus4,
    input  logic [31:0]       iinstr_fetch,
    output logic [31:0]       opc_fetch,
    output logic [31:0]       oinstr_decod,
    output logic [31:0]       opc_decod,
    output logic [31:0]       opc_plus4_decod,
    output logic              ovalid_decod,
    input  logic [4:0]        irs1_decod,
    input  logic [4:0]        irs2_decod,
    input  logic [4:0]        ird_decod,
    input  logic [31:0]       ird1_decod,
    input  logic [31:0]       ird2_decod,
    input  logic [31:0]       iimm_ext_decod,
    input  logic [CTRL_W-1:0] ictrl_decod,
    output logic [4:0]        ors1_exect,
    output logic [4:0]        ors2_exect,
    output logic [4:0]        ord_exect,
    output logic [31:0]       ord1_exect,
    output logic [31:0]       ord2_exect,
    output logic [31:0]       oimm_ext_exect,
    output logic [31:0]       opc_exect,
    output logic [31:0]       opc_plus4_exect,
    output logic [CTRL_W-1:0] octrl_exect,
    output logic              ovalid_exect,
    input  logic [1:0]        iforward_ae,
    input  logic [1:0]        iforward_be,
    input  logic [31:0]       ialu_result_mem,
    input  logic [31:0]       iresult_wrt,
    output logic [31:0]       osrc_a_exect,
    output logic [31:0]       owrite_data_exect,
    output logic [31:0]       ostall_cnt,
    output logic [31:0]       oflush_cnt
);

    localparam int unsigned IFID_W = 97;
    localparam int unsigned IDEX_W = 176 + CTRL_W;
    // A flushed or reset IF/ID slot holds a NOP with zero PCs and valid low.
    localparam logic [IFID_W-1:0] IFID_IDLE = {1'b0, NOP, 64'h0};

    logic [IFID_W-1:0] ifid_in;
    logic [IFID_W-1:0] ifid_out;
    logic [IDEX_W-1:0] idex_in;
    logic [IDEX_W-1:0] idex_out;
    logic [31:0]       stall_cnt_d;
    logic [31:0]       stall_cnt_q;
    logic [31:0]       flush_cnt_d;
    logic [31:0]       flush_cnt_q;

    pipe_reg #(
        .WIDTH  (32),
        .RST_VAL(RESET_PC),
        .CLR_VAL(RESET_PC)
    ) u_pc_reg (
        .iclk (iclk),
        .irst (irst),
        .ien  (~istall_fetch),
        .iclr (1'b0),
        .idata(ipc_next_fetch),
        .odata(opc_fetch)
    );

    assign ifid_in = {1'b1, iinstr_fetch, opc_fetch, ipc_fetch_plus4};

    pipe_reg #(
        .WIDTH  (IFID_W),
        .RST_VAL(IFID_IDLE),
        .CLR_VAL(IFID_IDLE)
    ) u_ifid_reg (
        .iclk (iclk),
        .irst (irst),
        .ien  (~istall_decod),
        .iclr (iflush_decod),
        .idata(ifid_in),
        .odata(ifid_out)
    );

    assign {ovalid_decod, oinstr_decod, opc_decod, opc_plus4_decod} = ifid_out;

    assign idex_in = {ovalid_decod, irs1_decod, irs2_decod, ird_decod, ird1_decod, ird2_decod,
                      iimm_ext_decod, opc_decod, opc_plus4_decod, ictrl_decod};

    pipe_reg #(
        .WIDTH  (IDEX_W),
        .RST_VAL('0),
        .CLR_VAL('0)
    ) u_idex_reg (
        .iclk (iclk),
        .irst (irst),
        .ien  (1'b1),
        .iclr (iflush_exect),
        .idata(idex_in),
        .odata(idex_out)
    );

    assign {ovalid_exect, ors1_exect, ors2_exect, ord_exect, ord1_exect, ord2_exect,
            oimm_ext_exect, opc_exect, opc_plus4_exect, octrl_exect} = idex_out;

    assign osrc_a_exect      = fwd_mux(iforward_ae, ord1_exect, iresult_wrt, ialu_result_mem);
    assign owrite_data_exect = fwd_mux(iforward_be, ord2_exect, iresult_wrt, ialu_result_mem);

    // A cycle with both flushes still counts as a single flush event.
    always_comb begin
        stall_cnt_d = istall_fetch ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (iflush_decod | iflush_exect) ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ostall_cnt = stall_cnt_q;
    assign oflush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CTRL_W, default 16, width of the decoded control bundle.
REQ-003 iclk  in  1  sole clock, all state updates on rising edge.
REQ-004 irst  in  1  reset, asynchronous, active-high.
REQ-005 istall_fetch, istall_decod, iflush_decod, iflush_exect  in  1 each  hazard controls.
REQ-006 ipc_next_fetch  in  32  next PC; ipc_fetch_plus4  in  32; iinstr_fetch  in  32  fetched instruction.
REQ-007 opc_fetch  out  32  current PC register.
REQ-008 oinstr_decod, opc_decod, opc_plus4_decod  out  32 each; ovalid_decod  out  1  IF/ID contents.
REQ-009 irs1_decod, irs2_decod, ird_decod  in  5 each; ird1_decod, ird2_decod, iimm_ext_decod  in  32 each; ictrl_decod  in  CTRL_W.
REQ-010 ors1_exect, ors2_exect, ord_exect  out  5; ord1_exect, ord2_exect, oimm_ext_exect, opc_exect, opc_plus4_exect  out  32; octrl_exect  out  CTRL_W; ovalid_exect  out  1  ID/EX contents.
REQ-011 iforward_ae, iforward_be  in  2; ialu_result_mem, iresult_wrt  in  32  forwarding sources.
REQ-012 osrc_a_exect, owrite_data_exect  out  32  forwarded operands.
REQ-013 ostall_cnt, oflush_cnt  out  32  performance counters.

Function
REQ-014 PC register SHALL load ipc_next_fetch each edge unless istall_fetch=1, then hold.
REQ-015 IF/ID SHALL, per edge, priority: iflush_decod=1 -> instr=32'h0000_0013 (NOP), pcs=0, valid=0; else istall_decod=1 -> hold; else load fetch inputs, valid=1.
REQ-016 ID/EX SHALL, per edge: iflush_exect=1 -> all fields 0, valid=0; else load decode inputs, valid=ovalid_decod; ID/EX has no stall.
REQ-017 Flush and stall asserted together on IF/ID SHALL resolve as flush.
REQ-018 osrc_a_exect SHALL be combinational, zero latency: 00 ord1_exect, 01 iresult_wrt, 10 ialu_result_mem, 11 ord1_exect.
REQ-019 owrite_data_exect SHALL select identically from iforward_be with ord2_exect as default.
REQ-020 ostall_cnt SHALL increment by 1 every cycle istall_fetch=1, saturating at 32'hFFFF_FFFF.
REQ-021 oflush_cnt SHALL increment by 1 every cycle (iflush_decod | iflush_exect)=1, once per cycle even if both, saturating at 32'hFFFF_FFFF.
REQ-022 Every output except forwarding muxes SHALL be a register output; no combinational input-to-output path outside REQ-018/019.

Reset
REQ-023 irst=1 SHALL immediately force opc_fetch=RESET_PC, oinstr_decod=NOP, all other IF/ID and ID/EX fields 0, both valids 0, both counters 0, independent of iclk.
REQ-024 Reset asserted mid-stall or mid-flush SHALL override; first edge after deassertion loads normally per REQ-014..016.

Structure
REQ-025 Shared package riscv_pkg SHALL hold NOP constant 32'h0000_0013 and forward encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
REQ-026 One sub-module pipe_reg (parameter WIDTH, enable, sync clear, async reset value) SHALL be instantiated for PC, IF/ID and ID/EX.

Verification
REQ-027 Reset release, ipc_next_fetch=pc+4 free-running -> opc_fetch 0,4,8 on successive edges; ovalid_decod 1 after first edge, ovalid_exect after second.
REQ-028 istall_fetch=istall_decod=1 and iflush_exect=1 for one cycle -> opc_fetch and oinstr_decod hold, ID/EX zeroed with ovalid_exect=0, ostall_cnt=1, oflush_cnt=1.
REQ-029 iflush_decod=iflush_exect=istall_decod=1 one cycle -> oinstr_decod=32'h0000_0013, ovalid_decod=0, ID/EX zeroed, oflush_cnt increments by exactly 1.
REQ-030 ord1_exect=5, ialu_result_mem=7, iresult_wrt=9; iforward_ae 00/01/10/11 -> osrc_a_exect 5/9/7/5 same cycle; same for B path.
REQ-031 Force ostall_cnt to 32'hFFFF_FFFE, stall 3 cycles -> holds 32'hFFFF_FFFF.
REQ-032 Assert irst between clock edges during stall -> outputs reach reset values before next edge.
